// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer.
//   hz_state_t : sequencer state (RUN, LDUSE, DWAIT, HALT)
//   regbits_t  : architectural register index
//   lu_cnt_t   : remaining load-use bubble count
//   is_zero_reg: true for $zero, which never creates a data dependency
package hazard_sequencer_pkg;

   localparam int REG_W    = 5;
   localparam int LU_CNT_W = 2;

   typedef logic [REG_W-1:0]    regbits_t;
   typedef logic [LU_CNT_W-1:0] lu_cnt_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LDUSE = 2'd1,
      DWAIT = 2'd2,
      HALT  = 2'd3
   } hz_state_t;

   function automatic logic is_zero_reg(input regbits_t r);
      return (r == {REG_W{1'b0}});
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of pipeline status inputs and stall/flush outputs of the hazard
// sequencer.
//   hs : sequencer side (status in, enables/flushes/halted/counter out)
//   tb : driver side (mirror image of hs)
interface hazard_sequencer_if
   import hazard_sequencer_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             dmemREN_mem;
   logic             dmemWEN_mem;
   logic             memread_ex;
   regbits_t         rw_ex;
   regbits_t         rs_id;
   regbits_t         rt_id;
   logic             uses_rt_id;
   logic             redirect_mem;
   logic             halt_wb;

   logic             pc_en;
   logic             en_ifid;
   logic             en_idex;
   logic             en_exmem;
   logic             en_memwb;
   logic             flush_ifid;
   logic             flush_idex;
   logic             flush_exmem;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;

   modport hs (
      input  ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex,
             rw_ex, rs_id, rt_id, uses_rt_id, redirect_mem, halt_wb,
      output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
             flush_ifid, flush_idex, flush_exmem, halted, stall_cycles
   );

   modport tb (
      output ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex,
             rw_ex, rs_id, rt_id, uses_rt_id, redirect_mem, halt_wb,
      input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
             flush_ifid, flush_idex, flush_exmem, halted, stall_cycles
   );
endinterface

// File: rtl/hazard_sequencer_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load still in EX, which forwarding cannot cover.
//   memread_ex : EX instruction is a load
//   rw_ex      : EX destination register
//   rs_id      : ID rs operand
//   rt_id      : ID rt operand
//   uses_rt_id : ID instruction actually reads rt
//   lu         : a bubble is required
module load_use_detect
   import hazard_sequencer_pkg::*;
(
   input  logic     memread_ex,
   input  regbits_t rw_ex,
   input  regbits_t rs_id,
   input  regbits_t rt_id,
   input  logic     uses_rt_id,
   output logic     lu
);
   logic rs_match_s;
   logic rt_match_s;

   // Operand comparisons against the load destination.
   always_comb begin
      rs_match_s = (rw_ex == rs_id);
      rt_match_s = uses_rt_id & (rw_ex == rt_id);
   end

   // $zero is hard-wired, so a load into it never creates a dependency.
   assign lu = memread_ex & ~is_zero_reg(rw_ex) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline.
// Sequences dcache waits, load-use bubbles and MEM-resolved redirects,
// latches halt and counts stall cycles.
//   CLK, RST : clock, asynchronous active-high reset
//   bus (hs) : pipeline status in; PC enable, latch enables, flushes,
//              halted flag and saturating stall-cycle counter out
// Parameters: LU_BUBBLES (1..3) bubbles per load-use hazard,
//             CNT_W stall counter width (must match the interface CNT_W).
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 32
)
(
   input  logic            CLK,
   input  logic            RST,
   hazard_sequencer_if.hs  bus
);
   // Out-of-range settings are clamped into the supported 1..3 window.
   localparam int LU_B_C = (LU_BUBBLES < 1) ? 1 : ((LU_BUBBLES > 3) ? 3 : LU_BUBBLES);
   localparam lu_cnt_t LU_RELOAD = lu_cnt_t'(LU_B_C - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_t        state_r;
   hz_state_t        state_n_s;
   lu_cnt_t          lu_cnt_r;
   lu_cnt_t          lu_cnt_n_s;
   logic [CNT_W-1:0] stall_r;

   logic dmiss_s;
   logic lu_s;
   logic pc_en_s;
   logic en_ifid_s;
   logic en_idex_s;
   logic en_exmem_s;
   logic en_memwb_s;
   logic flush_ifid_s;
   logic flush_idex_s;
   logic flush_exmem_s;

   load_use_detect u_lu (
      .memread_ex (bus.memread_ex),
      .rw_ex      (bus.rw_ex),
      .rs_id      (bus.rs_id),
      .rt_id      (bus.rt_id),
      .uses_rt_id (bus.uses_rt_id),
      .lu         (lu_s)
   );

   // A data access in MEM that the dcache did not satisfy this cycle.
   always_comb begin
      dmiss_s = (bus.dmemREN_mem | bus.dmemWEN_mem) & ~bus.dhit;
   end

   // Next-state and enable/flush decode; priority halt > dmiss > redirect > lu > ~ihit.
   always_comb begin
      state_n_s     = state_r;
      lu_cnt_n_s    = lu_cnt_r;
      pc_en_s       = 1'b1;
      en_ifid_s     = 1'b1;
      en_idex_s     = 1'b1;
      en_exmem_s    = 1'b1;
      en_memwb_s    = 1'b1;
      flush_ifid_s  = 1'b0;
      flush_idex_s  = 1'b0;
      flush_exmem_s = 1'b0;
      case (state_r)
         RUN, LDUSE: begin
            if (bus.halt_wb) begin
               {pc_en_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s} = 5'b00000;
               state_n_s = HALT;
            end else if (dmiss_s) begin
               // lu_cnt stays frozen so any owed bubbles resume after the wait.
               {pc_en_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s} = 5'b00000;
               state_n_s = DWAIT;
            end else if (bus.redirect_mem) begin
               {flush_ifid_s, flush_idex_s, flush_exmem_s} = 3'b111;
               lu_cnt_n_s = 2'd0;
               state_n_s  = RUN;
            end else if ((state_r == LDUSE) || lu_s) begin
               // Hold PC and IF/ID, inject a bubble into ID/EX, let the load move on.
               pc_en_s      = 1'b0;
               en_ifid_s    = 1'b0;
               flush_idex_s = 1'b1;
               if (state_r == LDUSE) begin
                  if (lu_cnt_r <= 2'd1) begin
                     lu_cnt_n_s = 2'd0;
                     state_n_s  = RUN;
                  end else begin
                     lu_cnt_n_s = lu_cnt_r - 2'd1;
                     state_n_s  = LDUSE;
                  end
               end else if (LU_B_C > 1) begin
                  lu_cnt_n_s = LU_RELOAD;
                  state_n_s  = LDUSE;
               end else begin
                  state_n_s = RUN;
               end
            end else if (!bus.ihit) begin
               pc_en_s      = 1'b0;
               flush_ifid_s = 1'b1;
            end else begin
               state_n_s = state_r;
            end
         end
         DWAIT: begin
            if (!bus.dhit) begin
               {pc_en_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s} = 5'b00000;
            end else if (bus.redirect_mem) begin
               // Fill cycle doubles as the redirect cycle.
               {flush_ifid_s, flush_idex_s, flush_exmem_s} = 3'b111;
               lu_cnt_n_s = 2'd0;
               state_n_s  = RUN;
            end else begin
               state_n_s = (lu_cnt_r != 2'd0) ? LDUSE : RUN;
            end
         end
         HALT: begin
            {pc_en_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s} = 5'b00000;
            state_n_s = HALT;
         end
         default: begin
            {pc_en_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s} = 5'b00000;
            lu_cnt_n_s = 2'd0;
            state_n_s  = RUN;
         end
      endcase
   end

   // State, bubble count and saturating stall counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r  <= RUN;
         lu_cnt_r <= 2'd0;
         stall_r  <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_n_s;
         lu_cnt_r <= lu_cnt_n_s;
         if (!pc_en_s && (state_r != HALT) && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_ONE;
         end else begin
            stall_r <= stall_r;
         end
      end
   end

   assign bus.pc_en        = pc_en_s;
   assign bus.en_ifid      = en_ifid_s;
   assign bus.en_idex      = en_idex_s;
   assign bus.en_exmem     = en_exmem_s;
   assign bus.en_memwb     = en_memwb_s;
   assign bus.flush_ifid   = flush_ifid_s;
   assign bus.flush_idex   = flush_idex_s;
   assign bus.flush_exmem  = flush_exmem_s;
   assign bus.halted       = (state_r == HALT);
   assign bus.stall_cycles = stall_r;

endmodule
